// File: rtl/fd_pkg.sv
// Shared types and helpers for the programmable clock divider.
package fd_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int MIN_DIV   = 2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STOPPING = 2'd1,
        ST_IDLE     = 2'd2
    } fd_state_e;

    // High-phase length for a given ratio: ceil(ratio/2).
    function automatic logic [31:0] hi_phase(input logic [31:0] ratio);
        return (ratio + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/fd_ratio_ctrl.sv
// Divide-ratio load capture, validation and boundary-aligned update.
module fd_ratio_ctrl
    import fd_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             apply_now,
    output logic [CNT_W-1:0] ratio_next,
    output logic [CNT_W-1:0] ratio_cur,
    output logic             load_pend,
    output logic             ratio_err
);

    logic [CNT_W-1:0] ratio_cur_q, ratio_cur_d;
    logic [CNT_W-1:0] pend_ratio_q, pend_ratio_d;
    logic             load_pend_q, load_pend_d;
    logic             ratio_err_q, ratio_err_d;
    logic             load_ok, load_bad;

    always_comb begin
        load_ok  = div_load && (div_ratio >= CNT_W'(MIN_DIV));
        load_bad = div_load && (div_ratio <  CNT_W'(MIN_DIV));

        // A load arriving on the apply edge is forwarded straight into effect.
        ratio_next = ratio_cur_q;
        if (apply_now) begin
            if (load_ok)
                ratio_next = div_ratio;
            else if (load_pend_q)
                ratio_next = pend_ratio_q;
        end

        ratio_cur_d  = ratio_next;
        pend_ratio_d = (load_ok && !apply_now) ? div_ratio : pend_ratio_q;
        load_pend_d  = apply_now ? 1'b0 : (load_ok ? 1'b1 : load_pend_q);
        ratio_err_d  = ratio_err_q | load_bad;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            ratio_cur_q  <= CNT_W'(DIV_DEFAULT);
            pend_ratio_q <= '0;
            load_pend_q  <= 1'b0;
            ratio_err_q  <= 1'b0;
        end else begin
            ratio_cur_q  <= ratio_cur_d;
            pend_ratio_q <= pend_ratio_d;
            load_pend_q  <= load_pend_d;
            ratio_err_q  <= ratio_err_d;
        end
    end

    assign ratio_cur = ratio_cur_q;
    assign load_pend = load_pend_q;
    assign ratio_err = ratio_err_q;

endmodule

// File: rtl/fd_prog_div.sv
// Programmable clock divider: run/stop FSM, phase counter and registered output.
module fd_prog_div
    import fd_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             div_out,
    output logic             period_tick,
    output logic [CNT_W-1:0] ratio_cur,
    output logic             load_pend,
    output logic             ratio_err,
    output logic             running
);

    fd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_out_q, div_out_d;
    logic             tick_q, tick_d;
    logic             in_period, boundary, apply_now;
    logic [CNT_W-1:0] ratio_next, hi_len;

    fd_ratio_ctrl #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ratio_ctrl (
        .clk        (clk),
        .rst        (rst),
        .div_load   (div_load),
        .div_ratio  (div_ratio),
        .apply_now  (apply_now),
        .ratio_next (ratio_next),
        .ratio_cur  (ratio_cur),
        .load_pend  (load_pend),
        .ratio_err  (ratio_err)
    );

    // While parked there is no period to protect, so loads apply at once.
    always_comb begin
        in_period = (state_q != ST_IDLE);
        boundary  = in_period && (cnt_q == ratio_cur - CNT_W'(1));
        apply_now = boundary || !in_period;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (!en) state_d = ST_STOPPING;
            ST_STOPPING: begin
                if (en)
                    state_d = ST_RUN;
                else if (boundary)
                    state_d = ST_IDLE;
            end
            ST_IDLE:     if (en) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_comb begin
        running = (state_q != ST_IDLE);
    end

    // The high-phase length follows the ratio that governs the period cnt_d belongs to.
    always_comb begin
        hi_len    = CNT_W'(hi_phase(32'(ratio_next)));
        cnt_d     = '0;
        div_out_d = 1'b0;
        tick_d    = 1'b0;
        if (state_d == ST_IDLE) begin
            cnt_d     = '0;
            div_out_d = 1'b0;
            tick_d    = 1'b0;
        end else if (state_q == ST_IDLE) begin
            cnt_d     = '0;
            div_out_d = 1'b1;
            tick_d    = 1'b1;
        end else begin
            cnt_d     = boundary ? '0 : cnt_q + CNT_W'(1);
            div_out_d = (cnt_d < hi_len);
            tick_d    = boundary;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            div_out_q <= 1'b1;
            tick_q    <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
        end
    end

    assign div_out     = div_out_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_fd_prog_div.sv
// Directed-vector bench for fd_prog_div; outputs sampled on the rising edge.
module tb_fd_prog_div;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_ratio;
    logic             div_load;
    logic             div_out;
    logic             period_tick;
    logic [CNT_W-1:0] ratio_cur;
    logic             load_pend;
    logic             ratio_err;
    logic             running;

    int vec_cnt = 0;
    int err_cnt = 0;

    fd_prog_div #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .div_ratio   (div_ratio),
        .div_load    (div_load),
        .div_out     (div_out),
        .period_tick (period_tick),
        .ratio_cur   (ratio_cur),
        .load_pend   (load_pend),
        .ratio_err   (ratio_err),
        .running     (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Shift div_out/period_tick samples in oldest-first (oldest ends up as MSB).
    task automatic run_cap(input int n, output logic [31:0] d, output logic [31:0] t);
        d = '0;
        t = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            d = {d[30:0], div_out};
            t = {t[30:0], period_tick};
        end
    endtask

    task automatic do_load(input logic [CNT_W-1:0] val);
        div_ratio = val;
        div_load  = 1'b1;
        @(posedge clk);
        div_load  = 1'b0;
    endtask

    initial begin
        logic [31:0] d, t;
        int          highs, ticks;
        bit          found;

        rst = 1'b0; en = 1'b1; div_load = 1'b0; div_ratio = '0;
        #1 rst = 1'b1;
        @(posedge clk);
        check("rst_div_out",   32'(div_out),     32'd1);
        check("rst_tick",      32'(period_tick), 32'd1);
        check("rst_ratio_cur", 32'(ratio_cur),   32'd2);
        check("rst_load_pend", 32'(load_pend),   32'd0);
        check("rst_ratio_err", 32'(ratio_err),   32'd0);
        check("rst_running",   32'(running),     32'd1);
        @(posedge clk);
        rst = 1'b0;

        // Default ratio 2
        run_cap(6, d, t);
        check("n2_div", d, 32'b010101);
        check("n2_tick", t, 32'b010101);

        // Load 5 mid-period
        do_load(8'd5);
        check("ld5_pend", 32'(load_pend), 32'd1);
        check("ld5_div",  32'(div_out),   32'd0);
        check("ld5_cur_before", 32'(ratio_cur), 32'd2);
        run_cap(10, d, t);
        check("n5_div",  d, 32'b1110011100);
        check("n5_tick", t, 32'b1000010000);
        check("n5_cur",  32'(ratio_cur), 32'd5);
        check("n5_pend", 32'(load_pend), 32'd0);

        // Two loads before one boundary: latest wins
        run_cap(1, d, t);
        do_load(8'd7);
        do_load(8'd4);
        check("ld74_pend", 32'(load_pend), 32'd1);
        check("ld74_cur",  32'(ratio_cur), 32'd5);
        run_cap(8, d, t);
        check("n4_div",  d, 32'b00110011);
        check("n4_tick", t, 32'b00100010);
        check("n4_cur",  32'(ratio_cur), 32'd4);

        // Illegal loads
        do_load(8'd0);
        check("ld0_err",  32'(ratio_err), 32'd1);
        check("ld0_pend", 32'(load_pend), 32'd0);
        do_load(8'd1);
        check("ld1_cur",  32'(ratio_cur), 32'd4);
        run_cap(4, d, t);
        check("bad_div", d, 32'b1100);

        // Load on a boundary edge is forwarded
        do_load(8'd3);
        check("fwd_pend", 32'(load_pend),   32'd0);
        check("fwd_cur",  32'(ratio_cur),   32'd3);
        check("fwd_tick", 32'(period_tick), 32'd1);
        run_cap(6, d, t);
        check("n3_div",  d, 32'b101101);
        check("n3_tick", t, 32'b001001);

        // Stop at cnt=1 of N=6, then restart
        do_load(8'd6);
        run_cap(3, d, t);
        check("n6_start", d, 32'b011);
        en = 1'b0;
        run_cap(5, d, t);
        check("stop_div",  d, 32'b10000);
        check("stop_tick", t, 32'b00000);
        check("stop_running", 32'(running), 32'd0);
        run_cap(3, d, t);
        check("idle_div", d, 32'b000);
        do_load(8'd4);
        check("idle_ld_cur",  32'(ratio_cur), 32'd4);
        check("idle_ld_pend", 32'(load_pend), 32'd0);
        en = 1'b1;
        @(posedge clk);
        check("restart_div",     32'(div_out),     32'd1);
        check("restart_tick",    32'(period_tick), 32'd1);
        check("restart_running", 32'(running),     32'd1);
        run_cap(4, d, t);
        check("restart_n4_div", d, 32'b1001);

        // Reset in high phase of N=9
        do_load(8'd9);
        run_cap(3, d, t);
        check("n9_enter", d, 32'b001);
        run_cap(2, d, t);
        check("n9_high", d, 32'b11);
        #2 rst = 1'b1;
        #1;
        check("mrst_div",  32'(div_out),     32'd1);
        check("mrst_tick", 32'(period_tick), 32'd1);
        check("mrst_cur",  32'(ratio_cur),   32'd2);
        check("mrst_err",  32'(ratio_err),   32'd0);
        @(posedge clk);
        rst = 1'b0;
        run_cap(4, d, t);
        check("mrst_n2_div", d, 32'b0101);

        // Maximum ratio 255: 128 high, 127 low, no overflow
        do_load(8'd255);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            if (period_tick) found = 1'b1;
        end
        check("n255_tick_seen", 32'(found), 32'd1);
        highs = int'(div_out);
        ticks = 0;
        for (int i = 0; i < 254; i++) begin
            @(posedge clk);
            highs += int'(div_out);
            ticks += int'(period_tick);
        end
        check("n255_highs", 32'(highs), 32'd128);
        check("n255_inner_ticks", 32'(ticks), 32'd0);
        @(posedge clk);
        check("n255_wrap_tick", 32'(period_tick), 32'd1);
        check("n255_cur", 32'(ratio_cur), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
